// File: rtl/rt_ibex_hws_sequencer_if.sv
// Mode type and handshake bundle between ibex_controller, the sequencer and the stacking unit.
// The master modport is the controller/stacking-unit side; the slave modport is the sequencer.
package rt_ibex_hws_pkg;
   typedef enum logic {HWS_SAVE = 1'b0, HWS_RESTORE = 1'b1} hw_stacking_mode_t;
endpackage

interface rt_ibex_hws_sequencer_if;
   import rt_ibex_hws_pkg::*;
   logic              entry_req_i;
   logic              entry_ready_o;
   logic              exit_req_i;
   logic              exit_ready_o;
   logic              irq_pending_i;
   logic              hws_start_o;
   hw_stacking_mode_t hws_mode_o;
   logic              hws_done_i;
   logic              hws_ack_o;
   logic              entry_done_o;
   logic              exit_done_o;
   logic              tail_chain_o;

   modport slave (
      input  entry_req_i, exit_req_i, irq_pending_i, hws_done_i,
      output entry_ready_o, exit_ready_o, hws_start_o, hws_mode_o, hws_ack_o,
             entry_done_o, exit_done_o, tail_chain_o
   );
   modport master (
      output entry_req_i, exit_req_i, irq_pending_i, hws_done_i,
      input  entry_ready_o, exit_ready_o, hws_start_o, hws_mode_o, hws_ack_o,
             entry_done_o, exit_done_o, tail_chain_o
   );
endinterface

// File: rtl/rt_ibex_hws_sequencer.sv
// RT-IBEX hardware stacking sequencer: arbitrates IRQ entry / mret exit, runs save/restore
// on the stacking unit, tracks nesting depth and tail-chains exits with a pending IRQ.
module rt_ibex_hws_sequencer
   import rt_ibex_hws_pkg::*;
#(
   parameter int MAX_DEPTH = 4,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1),
   parameter int TIMEOUT   = 64,
   parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   rt_ibex_hws_sequencer_if.slave bus,
   output logic                 busy_o,
   output logic [DEPTH_W-1:0]   depth_o,
   output logic                 overflow_o,
   output logic                 underflow_o,
   output logic                 timeout_o
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACK, S_DRAIN} state_e;

   state_e            state_q, state_d;
   hw_stacking_mode_t mode_q, mode_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [TO_W-1:0]   wdog_q, wdog_d;
   logic              ovf_q, ovf_d, unf_q, unf_d, to_q, to_d, tail_q, tail_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         mode_q  <= HWS_SAVE;
         depth_q <= '0;
         wdog_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         to_q    <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         depth_q <= depth_d;
         wdog_q  <= wdog_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         to_q    <= to_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      mode_d            = mode_q;
      depth_d           = depth_q;
      wdog_d            = wdog_q;
      ovf_d             = ovf_q;
      unf_d             = unf_q;
      to_d              = to_q;
      tail_d            = 1'b0;
      bus.entry_ready_o = 1'b0;
      bus.exit_ready_o  = 1'b0;
      bus.hws_start_o   = 1'b0;
      bus.hws_ack_o     = 1'b0;
      bus.entry_done_o  = 1'b0;
      bus.exit_done_o   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Readies are masked during reset so every output reads 0 while rst_i is high.
            bus.entry_ready_o = ~rst_i;
            bus.exit_ready_o  = ~rst_i;
            if (bus.exit_req_i) begin
               if (depth_q == '0) begin
                  unf_d = 1'b1;
               end else if (bus.irq_pending_i) begin
                  tail_d = 1'b1;
               end else begin
                  mode_d  = HWS_RESTORE;
                  state_d = S_START;
               end
            end else if (bus.entry_req_i) begin
               if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  mode_d  = HWS_SAVE;
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            bus.hws_start_o = 1'b1;
            wdog_d          = '0;
            state_d         = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + TO_W'(1);
            if (bus.hws_done_i) begin
               state_d = S_ACK;
               if (mode_q == HWS_SAVE) begin
                  depth_d          = depth_q + DEPTH_W'(1);
                  bus.entry_done_o = 1'b1;
               end else begin
                  depth_d         = depth_q - DEPTH_W'(1);
                  bus.exit_done_o = 1'b1;
               end
            end else if (wdog_q == TO_W'(TIMEOUT - 1)) begin
               // Give up on this transfer: ack to release the unit, depth untouched.
               to_d          = 1'b1;
               bus.hws_ack_o = 1'b1;
               state_d       = S_DRAIN;
            end
         end
         S_ACK: begin
            bus.hws_ack_o = 1'b1;
            state_d       = S_DRAIN;
         end
         S_DRAIN: begin
            if (!bus.hws_done_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.hws_mode_o   = mode_q;
   assign bus.tail_chain_o = tail_q;
   assign busy_o           = (state_q != S_IDLE);
   assign depth_o          = depth_q;
   assign overflow_o       = ovf_q;
   assign underflow_o      = unf_q;
   assign timeout_o        = to_q;

endmodule
